// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD stop-watch count controller.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single decade (BCD) counter stage with synchronous clear and terminal-count output.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       tc
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Out-of-range codes behave as 9: they carry and reload 0.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (en) begin
            q_d = (q_q >= BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = en & (q_q >= BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear controller for a cascade of BCD digit stages, with lap freeze and overflow.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count_o,
    output logic [4*DIGITS-1:0]   disp_o,
    output logic                  running_o,
    output logic                  lap_o,
    output logic                  ovf_o,
    output logic [1:0]            state_o
);

    localparam int unsigned CW = 4 * DIGITS;

    state_e          state_q, state_d;
    logic            lap_q, lap_d;
    logic [CW-1:0]   lap_reg_q, lap_reg_d;
    logic            ovf_q, ovf_d;

    logic            in_run_c;
    logic            all_nines_c;
    logic            sat_hit_c;
    logic [DIGITS:0] carry;

    assign in_run_c = (state_q == ST_RUN);

    always_comb begin
        all_nines_c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (count_o[4*i +: 4] < BCD_MAX) all_nines_c = 1'b0;
        end
    end

    assign sat_hit_c = tick & in_run_c & all_nines_c;
    // In saturating mode the cascade is frozen at all-9s instead of wrapping.
    assign carry[0]  = tick & in_run_c & ~(SATURATE & all_nines_c);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk (clk),
            .rst (rst),
            .clr (clear),
            .en  (carry[g]),
            .q   (count_o[4*g +: 4]),
            .tc  (carry[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lap_q     <= 1'b0;
            lap_reg_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lap_q     <= lap_d;
            lap_reg_q <= lap_reg_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next state: clear > stop > start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start) state_d = ST_RUN;
                ST_RUN: begin
                    if (stop)                       state_d = ST_PAUSE;
                    else if (SATURATE && sat_hit_c) state_d = ST_DONE;
                end
                ST_PAUSE: if (start) state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Lap freeze captures the pre-tick count; overflow pulses or sticks by mode.
    always_comb begin
        lap_d     = lap_q;
        lap_reg_d = lap_reg_q;
        ovf_d     = ovf_q;
        if (clear) begin
            lap_d     = 1'b0;
            lap_reg_d = '0;
            ovf_d     = 1'b0;
        end else begin
            if (lap) begin
                if (lap_q) begin
                    lap_d = 1'b0;
                end else if (state_q != ST_IDLE) begin
                    lap_d     = 1'b1;
                    lap_reg_d = count_o;
                end
            end
            if (SATURATE) ovf_d = ovf_q | sat_hit_c;
            else          ovf_d = carry[DIGITS];
        end
    end

    always_comb begin
        running_o = in_run_c;
        lap_o     = lap_q;
        ovf_o     = ovf_q;
        state_o   = state_q;
        disp_o    = lap_q ? lap_reg_q : count_o;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Run/pause/clear controller sequencing a cascade of DIGITS decade (BCD) counter stages from a shared count-enable tick.
Owns the stage enables and carries, the stop-watch state machine, lap (display freeze) capture, and overflow handling.
Sits between debounced user command pulses and the 7-segment/display path; each digit counts 0..9 and wraps like a single decade stage.

Parameters:
DIGITS, 4, number of cascaded decade stages; count width = 4*DIGITS.
SATURATE, 0, 0 = wrap at all-9s with 1-cycle ovf pulse; 1 = hold at all-9s, enter DONE, sticky ovf.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous active-low reset.
tick  input  1  count-enable pulse, 1 cycle wide; advances count by 1 when in RUN.
start  input  1  command pulse: begin/resume counting.
stop  input  1  command pulse: pause counting.
clear  input  1  command pulse: zero count, return to IDLE.
lap  input  1  command pulse: toggle display freeze.
count_o  output  4*DIGITS  live BCD count, digit 0 in [3:0].
disp_o  output  4*DIGITS  display value: lap register when frozen, else count_o.
running_o  output  1  high while state == RUN.
lap_o  output  1  high while display frozen.
ovf_o  output  1  overflow indication (see SATURATE).
state_o  output  2  current FSM state encoding.

Behaviour:
- Reset (rst low, async): state IDLE, count 0, lap register 0, lap_o 0, ovf_o 0; all outputs registered or derived from registers, so all read 0.
- States: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- Command priority each cycle: clear > stop > start; lap evaluated independently, except clear overrides it.
- clear (any state): next state IDLE, count 0, ovf_o 0, lap_o 0, lap register 0; concurrent tick ignored.
- start: IDLE->RUN, PAUSE->RUN; ignored in RUN and DONE.
- stop: RUN->PAUSE; ignored elsewhere. start+stop same cycle -> stop wins.
- Counting: only when current state == RUN and tick == 1 at the edge. A tick coinciding with start from IDLE/PAUSE is not counted. A tick coinciding with stop in RUN is counted.
- Latency: count_o shows new value the cycle after the tick edge.
- Digit carry: digit i increments iff tick, state RUN, and digits 0..i-1 all == 9. Carry ripples combinationally through all stages in one cycle. Digit at 9 with enable goes to 0. Values 10..15 are unreachable; if present, treat as 9 for carry and reload 0.
- All-9s with tick, SATURATE=0: count -> 0, ovf_o high exactly one cycle, remain RUN.
- All-9s with tick, SATURATE=1: count holds all-9s, state -> DONE, ovf_o high and sticky until clear or reset. In DONE only clear has effect; lap still toggles.
- lap pulse, lap_o=0, state RUN/PAUSE/DONE: capture count_o into lap register, lap_o->1. If tick advances the count on the same edge, the pre-increment value is captured.
- lap pulse, lap_o=1: lap_o->0. lap in IDLE ignored.
- disp_o = lap_o ? lap register : count_o. The count keeps advancing underneath a frozen display.
- Reset asserted mid-count: immediate async return to the reset values above; no partial carries survive.

Decomposition:
- Shared package bcd_ctrl_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and BCD_MAX = 4'd9.
- One sub-module bcd_digit: a single decade stage (clk, rst, clr, en -> q[3:0], tc = en & q==9).
- Instantiate bcd_digit DIGITS times via generate. Digit i's en is digit i-1's tc; digit 0's en is tick & RUN.
- The FSM, lap logic and overflow logic live in the top.

Test Plan:
- Reset, then DIGITS=2, start, 12 ticks -> count_o=8'h12, running_o=1, state_o=01; a tick in the start cycle is not counted.
- Count to 8'h09, one tick -> 8'h10 the next cycle; at 8'h99, one tick with SATURATE=0 -> 8'h00, ovf_o high exactly 1 cycle, state RUN.
- SATURATE=1 at 8'h99, tick -> count stays 8'h99, state DONE, ovf_o sticky; start/stop ignored; clear -> IDLE, 8'h00, ovf_o 0.
- At 8'h25, lap -> disp_o=8'h25, lap_o=1; 5 more ticks -> count_o=8'h30, disp_o still 8'h25; lap -> disp_o=8'h30.
- At 8'h40, stop+start+tick same cycle -> PAUSE, count 8'h41; further ticks hold 8'h41; start -> RUN.
- Drop rst asynchronously mid-cycle while at 8'h57 with lap_o=1 -> all outputs 0 immediately without waiting for a clk edge; clear+tick same cycle -> IDLE, 8'h00.
